lock_sequencer: RTL
===================

# lock_sequencer

Sequencing controller for the combination-lock design: edge-detects the user's enter button, steps through a CODE_LEN-digit entry, and compares it against a stored code. It counts failed attempts, enforces a timed lockout, and auto-relocks an opened lock after inactivity. It sits between the tt_um top-level pins (digit on ui_in[3:0], enter on ui_in[7]) and the LED outputs, replacing ad-hoc single-digit checking with a full multi-digit sequence.

## Interface
- CODE_LEN, 4: digits per code (2..8).
- DEFAULT_CODE, 16'h1234: reset code, 4 bits per digit, first digit in the most-significant nibble; width 4*CODE_LEN.
- MAX_FAILS, 3: consecutive failed codes that trigger lockout (1..7).
- ERROR_CYCLES, 16: duration of the ERROR display.
- LOCKOUT_CYCLES, 1024: duration of LOCKOUT.
- IDLE_CYCLES, 4096: inactivity limit in ENTRY and OPEN.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; asynchronous and active-low.
- digit  in  4  digit value, sampled on an enter press.
- enter  in  1  button level, already synchronous to clk.
- prog  in  1  reprogram request; only meaningful with LOCK_REPROGRAM_EN.
- locked  out  1  high in LOCKED and ENTRY.
- unlocked  out  1  high in OPEN and PROG.
- error  out  1  high in ERROR.
- lockout  out  1  high in LOCKOUT.
- state  out  3  state encoding: LOCKED=0, ENTRY=1, OPEN=2, ERROR=3, LOCKOUT=4, PROG=5.
- fail_cnt  out  3  current consecutive-failure count.

## Operation
- **Press detection:** a press is `enter==1 && enter_q==0`. `enter_q` is a register that resets to 1, so a button held through reset is not counted until it is released.
- **LOCKED:** on a press, capture the digit as index 0, set `mismatch = (digit != code[0])`, and go to ENTRY. If CODE_LEN is reached on this press, go straight to evaluation.
- **ENTRY:** each press ORs its mismatch into `mismatch` and increments the index. There is no early reject; the lock never reveals which digit was wrong.
  - On the CODE_LEN-th press, evaluate:
    - No mismatch: go to OPEN and clear fail_cnt.
    - Mismatch: increment fail_cnt. If it reaches MAX_FAILS, go to LOCKOUT; otherwise go to ERROR.
  - IDLE_CYCLES with no press: go to LOCKED, discard the entry, and leave fail_cnt unchanged.
- **ERROR:** presses are ignored. After ERROR_CYCLES, go to LOCKED.
- **LOCKOUT:** presses are ignored. After LOCKOUT_CYCLES, clear fail_cnt and go to LOCKED.
- **OPEN:**
  - A press with digit==4'hF relocks immediately: go to LOCKED.
  - Any other press restarts the idle timer.
  - IDLE_CYCLES with no press: go to LOCKED.
- A single cycle counter serves ENTRY, OPEN, ERROR and LOCKOUT. It clears on every state change and on every counted press. Its width is clog2 of the largest of the three cycle parameters.
- **Simultaneous events:** a press in the same cycle as a timer expiry is taken as the press; the timeout is not applied.

## Timing
- The state register updates on the clk edge that samples the press or the expiry. All outputs are decoded from the state and fail_cnt registers only, so they change one edge after the triggering event.
- End-to-end latency: the final digit press produces unlocked/error/lockout high after exactly 1 edge.
- ERROR is high for exactly ERROR_CYCLES cycles and LOCKOUT for exactly LOCKOUT_CYCLES cycles. OPEN with no presses lasts exactly IDLE_CYCLES cycles.
- **Reset (asynchronous):**
  - state = LOCKED, locked = 1, all other flag outputs 0.
  - fail_cnt = 0, timers and index = 0, enter_q = 1, code = DEFAULT_CODE.
- Reset asserted mid-entry, mid-lockout or mid-programming aborts the operation immediately. A partially written code is discarded.

## Configuration
- **LOCK_REPROGRAM_EN defined:**
  - In OPEN, a press with prog==1 enters PROG; that press's digit is not stored.
  - The next CODE_LEN presses are written to a shadow register.
  - After the last press, the shadow is copied to the code register in one edge, then the block returns to OPEN with the idle timer restarted.
  - IDLE_CYCLES with no press in PROG: return to LOCKED and leave the code unchanged.
- **LOCK_REPROGRAM_EN undefined:**
  - The code is the constant DEFAULT_CODE.
  - prog is ignored and the PROG state is unreachable.
  - No code or shadow registers are synthesized.

## Test plan
- Reset with enter held high, then release and press 1,2,3,4 -> no press counted before release; unlocked=1 one edge after the 4th press; fail_cnt=0.
- Press 1,2,3,5 -> error=1 for 16 cycles, fail_cnt=1, then locked=1.
- Three wrong codes in a row -> lockout=1 and state=4 for 1024 cycles, presses ignored during it; then fail_cnt=0 and locked=1.
- Correct code, then no presses -> back to LOCKED after 4096 cycles. Separately, correct code then a press with digit F -> LOCKED one edge later.
- Press 1,2, then idle 4096 cycles, then press 1,2,3,4 -> opens, and the abandoned entry does not increment fail_cnt.
- With LOCK_REPROGRAM_EN: open, press with prog=1, enter 9,8,7,6, wait for relock -> 1,2,3,4 fails and 9,8,7,6 opens. Assert rst_n mid-PROG -> 1,2,3,4 opens again.

Source files
------------

// File: rtl/lock_sequencer.sv
// Multi-digit combination lock sequencer with failed-attempt counting, timed lockout and idle relock.
// Optional code reprogramming from the OPEN state is enabled by defining LOCK_REPROGRAM_EN.
module lock_sequencer #(
  parameter int                    CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 16'h1234,
  parameter int                    MAX_FAILS      = 3,
  parameter int                    ERROR_CYCLES   = 16,
  parameter int                    LOCKOUT_CYCLES = 1024,
  parameter int                    IDLE_CYCLES    = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       prog,
  output logic       locked,
  output logic       unlocked,
  output logic       error,
  output logic       lockout,
  output logic [2:0] state,
  output logic [2:0] fail_cnt
);

  localparam int MAX_A   = (ERROR_CYCLES > LOCKOUT_CYCLES) ? ERROR_CYCLES : LOCKOUT_CYCLES;
  localparam int MAX_CYC = (MAX_A > IDLE_CYCLES) ? MAX_A : IDLE_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC);
  localparam int IDX_W   = $clog2(CODE_LEN);

  typedef enum logic [2:0] {
    S_LOCKED  = 3'd0,
    S_ENTRY   = 3'd1,
    S_OPEN    = 3'd2,
    S_ERROR   = 3'd3,
    S_LOCKOUT = 3'd4,
    S_PROG    = 3'd5
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_index;
  logic               r_mismatch;
  logic [TMR_W-1:0]   r_timer;
  logic [2:0]         r_fails;
  logic               r_enterQ;
  logic               r_locked;
  logic               r_unlocked;
  logic               r_error;
  logic               r_lockout;

  state_t             w_nState;
  logic [IDX_W-1:0]   w_nIndex;
  logic               w_nMismatch;
  logic [TMR_W-1:0]   w_nTimer;
  logic [2:0]         w_nFails;
  logic               w_press;
  logic               w_lastDigit;
  logic               w_idleDone;
  logic               w_newMis;
  logic [2:0]         w_failsInc;
  logic [3:0]         w_expDigit;
  logic [4*CODE_LEN-1:0] w_code;

`ifdef LOCK_REPROGRAM_EN
  logic [4*CODE_LEN-1:0] r_code;
  logic [4*CODE_LEN-1:0] r_shadow;
  logic [4*CODE_LEN-1:0] w_nCode;
  logic [4*CODE_LEN-1:0] w_nShadow;
  assign w_code = r_code;
`else
  logic w_unused;
  assign w_unused = prog;
  assign w_code   = DEFAULT_CODE;
`endif

  assign w_press     = enter & ~r_enterQ;
  assign w_lastDigit = (r_index == IDX_W'(CODE_LEN - 1));
  assign w_idleDone  = (r_timer == TMR_W'(IDLE_CYCLES - 1));
  assign w_failsInc  = r_fails + 3'd1;
  assign w_newMis    = ((r_state == S_ENTRY) && r_mismatch) || (digit != w_expDigit);

  always_comb begin
    w_expDigit = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (r_index == IDX_W'(i)) w_expDigit = w_code[(CODE_LEN-1-i)*4 +: 4];
    end
  end

  // Next-state logic; the shared timer restarts on any counted press and on every state change.
  always_comb begin
    w_nState    = r_state;
    w_nIndex    = r_index;
    w_nMismatch = r_mismatch;
    w_nTimer    = r_timer + TMR_W'(1);
    w_nFails    = r_fails;
`ifdef LOCK_REPROGRAM_EN
    w_nCode     = r_code;
    w_nShadow   = r_shadow;
`endif
    case (r_state)
      S_LOCKED, S_ENTRY: begin
        if (w_press) begin
          w_nTimer = '0;
          if (w_lastDigit) begin
            w_nIndex    = '0;
            w_nMismatch = 1'b0;
            if (!w_newMis) begin
              w_nState = S_OPEN;
              w_nFails = '0;
            end else begin
              w_nFails = w_failsInc;
              w_nState = (w_failsInc == 3'(MAX_FAILS)) ? S_LOCKOUT : S_ERROR;
            end
          end else begin
            w_nState    = S_ENTRY;
            w_nIndex    = r_index + IDX_W'(1);
            w_nMismatch = w_newMis;
          end
        end else if (r_state == S_LOCKED) begin
          w_nTimer = '0;
        end else if (w_idleDone) begin
          w_nState    = S_LOCKED;
          w_nIndex    = '0;
          w_nMismatch = 1'b0;
        end
      end
      S_ERROR: begin
        if (r_timer == TMR_W'(ERROR_CYCLES - 1)) w_nState = S_LOCKED;
      end
      S_LOCKOUT: begin
        if (r_timer == TMR_W'(LOCKOUT_CYCLES - 1)) begin
          w_nState = S_LOCKED;
          w_nFails = '0;
        end
      end
      S_OPEN: begin
        if (w_press) begin
          w_nTimer = '0;
          if (digit == 4'hF) begin
            w_nState = S_LOCKED;
`ifdef LOCK_REPROGRAM_EN
          end else if (prog) begin
            w_nState = S_PROG;
            w_nIndex = '0;
`endif
          end
        end else if (w_idleDone) begin
          w_nState = S_LOCKED;
        end
      end
`ifdef LOCK_REPROGRAM_EN
      S_PROG: begin
        if (w_press) begin
          w_nTimer = '0;
          for (int i = 0; i < CODE_LEN; i++) begin
            if (r_index == IDX_W'(i)) w_nShadow[(CODE_LEN-1-i)*4 +: 4] = digit;
          end
          if (w_lastDigit) begin
            w_nCode  = w_nShadow;
            w_nState = S_OPEN;
            w_nIndex = '0;
          end else begin
            w_nIndex = r_index + IDX_W'(1);
          end
        end else if (w_idleDone) begin
          w_nState = S_LOCKED;
          w_nIndex = '0;
        end
      end
`endif
      default: begin
        w_nState = S_LOCKED;
        w_nIndex = '0;
      end
    endcase
    if (w_nState != r_state) w_nTimer = '0;
  end

  // Flag outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_LOCKED;
      r_index    <= '0;
      r_mismatch <= 1'b0;
      r_timer    <= '0;
      r_fails    <= '0;
      r_enterQ   <= 1'b1;
      r_locked   <= 1'b1;
      r_unlocked <= 1'b0;
      r_error    <= 1'b0;
      r_lockout  <= 1'b0;
`ifdef LOCK_REPROGRAM_EN
      r_code     <= DEFAULT_CODE;
      r_shadow   <= '0;
`endif
    end else begin
      r_state    <= w_nState;
      r_index    <= w_nIndex;
      r_mismatch <= w_nMismatch;
      r_timer    <= w_nTimer;
      r_fails    <= w_nFails;
      r_enterQ   <= enter;
      r_locked   <= (w_nState == S_LOCKED) || (w_nState == S_ENTRY);
      r_unlocked <= (w_nState == S_OPEN) || (w_nState == S_PROG);
      r_error    <= (w_nState == S_ERROR);
      r_lockout  <= (w_nState == S_LOCKOUT);
`ifdef LOCK_REPROGRAM_EN
      r_code     <= w_nCode;
      r_shadow   <= w_nShadow;
`endif
    end
  end

  assign locked   = r_locked;
  assign unlocked = r_unlocked;
  assign error    = r_error;
  assign lockout  = r_lockout;
  assign state    = r_state;
  assign fail_cnt = r_fails;

endmodule
